// File: rtl/tcam_pkg.sv
// Shared defaults and FSM state type for the sequential TCAM search bank.
package tcam_pkg;
    localparam int KEY_W_DEF = 8;
    localparam int DEPTH_DEF = 16;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/tcam_bit_cmp.sv
// One ternary bit compare built as a Fredkin (controlled-swap) gate:
// control A = mask, B = xnor(data, key), C = 1; bit_ok is the Q output.
module tcam_bit_cmp (
    input  logic mask,
    input  logic data,
    input  logic key,
    output logic bit_ok
);
    localparam logic C_IN = 1'b1;

    logic b_in;
    logic route_b;
    logic route_c;

    assign b_in    = ~(data ^ key);
    // Q takes B when the control is low and the swapped-in C when it is high.
    assign route_b = ~mask & b_in;
    assign route_c = mask & C_IN;
    assign bit_ok  = route_b | route_c;
endmodule

// File: rtl/tcam_seq_search.sv
// Sequential ternary CAM: scans one entry per cycle and reports the lowest matching index.
// Optional macro TCAM_MULTI_HIT_EN: full scan every search plus a multi_hit output.
module tcam_seq_search
    import tcam_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [KEY_W-1:0] wr_data,
    input  logic [KEY_W-1:0] wr_mask,
    input  logic             wr_valid,
    input  logic             srch_start,
    input  logic [KEY_W-1:0] srch_key,
    output logic             busy,
    output logic             done,
    output logic             hit,
    output logic [IDX_W-1:0] hit_idx
`ifdef TCAM_MULTI_HIT_EN
    ,
    output logic             multi_hit
`endif
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [KEY_W-1:0] data_mem [DEPTH];
    logic [KEY_W-1:0] mask_mem [DEPTH];
    logic [DEPTH-1:0] valid_mem;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [KEY_W-1:0] key_q;
    logic [KEY_W-1:0] bit_ok;
    logic             entry_match;
    logic             at_last;
    logic             scan_end;
    logic             wr_ok;

    assign wr_ok = wr_en & ~busy;

    // NOTE: data/mask storage has no reset; valid_mem alone decides whether an entry can match.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            data_mem[wr_idx] <= wr_data;
            mask_mem[wr_idx] <= wr_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_mem <= '0;
        end else if (wr_ok) begin
            valid_mem[wr_idx] <= wr_valid;
        end
    end

    for (genvar b = 0; b < KEY_W; b++) begin : g_bit
        tcam_bit_cmp u_bit_cmp (
            .mask   (mask_mem[ptr][b]),
            .data   (data_mem[ptr][b]),
            .key    (key_q[b]),
            .bit_ok (bit_ok[b])
        );
    end

    assign entry_match = valid_mem[ptr] & (&bit_ok);
    assign at_last     = (ptr == LAST_IDX);
`ifdef TCAM_MULTI_HIT_EN
    assign scan_end    = at_last;
`else
    assign scan_end    = entry_match | at_last;
`endif

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (srch_start) state_nxt = SCAN;
            SCAN: begin
                busy = 1'b1;
                if (scan_end) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            key_q   <= '0;
            hit     <= 1'b0;
            hit_idx <= '0;
`ifdef TCAM_MULTI_HIT_EN
            multi_hit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (srch_start) begin
                    key_q   <= srch_key;
                    ptr     <= '0;
                    hit     <= 1'b0;
                    hit_idx <= '0;
`ifdef TCAM_MULTI_HIT_EN
                    multi_hit <= 1'b0;
`endif
                end
                SCAN: begin
`ifdef TCAM_MULTI_HIT_EN
                    // First match fixes hit_idx; any later match flags a multi-hit.
                    if (entry_match) begin
                        if (!hit) begin
                            hit     <= 1'b1;
                            hit_idx <= ptr;
                        end else begin
                            multi_hit <= 1'b1;
                        end
                    end
                    if (!at_last) ptr <= ptr + 1'b1;
`else
                    if (entry_match) begin
                        hit     <= 1'b1;
                        hit_idx <= ptr;
                    end else if (!at_last) begin
                        ptr <= ptr + 1'b1;
                    end else begin
                        hit <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_tcam_seq_search.sv
// Randomized self-checking bench for tcam_seq_search against an array-based reference model.
module tb_tcam_seq_search;
    localparam int KEY_W = 8;
    localparam int DEPTH = 16;
    localparam int IDX_W = 4;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [KEY_W-1:0] wr_data;
    logic [KEY_W-1:0] wr_mask;
    logic             wr_valid;
    logic             srch_start;
    logic [KEY_W-1:0] srch_key;
    logic             busy;
    logic             done;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
`ifdef TCAM_MULTI_HIT_EN
    logic             multi_hit;
`endif

    tcam_seq_search dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .wr_mask    (wr_mask),
        .wr_valid   (wr_valid),
        .srch_start (srch_start),
        .srch_key   (srch_key),
        .busy       (busy),
        .done       (done),
        .hit        (hit),
        .hit_idx    (hit_idx)
`ifdef TCAM_MULTI_HIT_EN
        ,
        .multi_hit  (multi_hit)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [KEY_W-1:0] m_data  [DEPTH];
    logic [KEY_W-1:0] m_mask  [DEPTH];
    bit               m_valid [DEPTH];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: lowest valid entry whose unmasked bits all equal the key, plus match count.
    task automatic ref_lookup(input logic [KEY_W-1:0] key, output bit e_hit,
                              output int e_idx, output int e_cnt);
        e_hit = 0;
        e_idx = 0;
        e_cnt = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && (((m_data[i] ^ key) & ~m_mask[i]) == '0)) begin
                if (!e_hit) e_idx = i;
                e_hit = 1;
                e_cnt++;
            end
        end
    endtask

    task automatic write_entry(input int idx, input logic [KEY_W-1:0] d,
                               input logic [KEY_W-1:0] m, input bit v);
        @(negedge clk);
        wr_en    = 1'b1;
        wr_idx   = IDX_W'(idx);
        wr_data  = d;
        wr_mask  = m;
        wr_valid = v;
        @(negedge clk);
        wr_en    = 1'b0;
        m_data[idx]  = d;
        m_mask[idx]  = m;
        m_valid[idx] = v;
    endtask

    // mode 0: plain search; mode 1: write + restart injected mid-scan (both must be dropped);
    // mode 2: write to w_idx with the search key in the same cycle as the accepted start.
    task automatic run_search(input string tag, input logic [KEY_W-1:0] key,
                              input int mode, input int w_idx);
        bit e_hit;
        int e_idx, e_cnt, e_lat;
        int lat, pulses, got_lat;
        bit busy_bad, got_hit, got_multi;
        int got_idx;

        @(negedge clk);
        srch_start = 1'b1;
        srch_key   = key;
        if (mode == 2) begin
            wr_en    = 1'b1;
            wr_idx   = IDX_W'(w_idx);
            wr_data  = key;
            wr_mask  = '0;
            wr_valid = 1'b1;
            m_data[w_idx]  = key;
            m_mask[w_idx]  = '0;
            m_valid[w_idx] = 1;
        end
        ref_lookup(key, e_hit, e_idx, e_cnt);
`ifdef TCAM_MULTI_HIT_EN
        e_lat = DEPTH + 1;
`else
        e_lat = e_hit ? e_idx + 2 : DEPTH + 1;
`endif
        @(negedge clk);
        lat = 1; pulses = 0; got_lat = 0; busy_bad = 0;
        got_hit = 0; got_idx = 0; got_multi = 0;
        repeat (DEPTH + 6) begin
            if (done) begin
                pulses++;
                if (got_lat == 0) begin
                    got_lat = lat;
                    got_hit = hit;
                    got_idx = int'(hit_idx);
`ifdef TCAM_MULTI_HIT_EN
                    got_multi = multi_hit;
`endif
                end
            end
            if (got_lat == 0 && !busy) busy_bad = 1;
            if (mode == 1 && lat == 2) begin
                wr_en      = 1'b1;
                wr_idx     = '0;
                wr_data    = key;
                wr_mask    = '0;
                wr_valid   = 1'b1;
                srch_start = 1'b1;
                srch_key   = key;
            end else begin
                wr_en      = 1'b0;
                srch_start = 1'b0;
                if (lat == 1) srch_key = KEY_W'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, got_lat, e_lat);
        check({tag, "_pulses"}, pulses, 1);
        check({tag, "_busy_scan"}, busy_bad, 0);
        check({tag, "_hit"}, got_hit, e_hit);
        check({tag, "_hit_idx"}, got_idx, e_idx);
`ifdef TCAM_MULTI_HIT_EN
        check({tag, "_multi"}, got_multi, e_cnt >= 2);
`else
        got_multi = (e_cnt >= 2);
`endif
        check({tag, "_busy_after"}, busy, 0);
        check({tag, "_hit_held"}, hit, e_hit);
        check({tag, "_idx_held"}, hit_idx, e_idx);
    endtask

    initial begin
        int pulses;
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; wr_mask = '0; wr_valid = 1'b0;
        srch_start = 1'b0; srch_key = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0; m_mask[i] = '0; m_valid[i] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_idx", hit_idx, 0);
        rst = 1'b0;

        run_search("empty_miss", 8'h00, 0, 0);

        write_entry(3, 8'hA5, 8'h00, 1);
        run_search("exact_hit3", 8'hA5, 0, 0);
        run_search("exact_miss", 8'hA4, 0, 0);

        write_entry(1, 8'hA0, 8'h0F, 1);
        run_search("tern_hit1", 8'hAF, 0, 0);
        run_search("tern_miss", 8'hBF, 0, 0);

        write_entry(2, 8'h3C, 8'h00, 1);
        write_entry(5, 8'h3C, 8'h00, 1);
        run_search("dual_hit2", 8'h3C, 0, 0);

        write_entry(4, 8'h5A, 8'hFF, 0);
        run_search("invalid_dc", 8'h11, 0, 0);

        run_search("same_cycle_wr", 8'hC3, 2, 0);
        write_entry(0, 8'h00, 8'h00, 0);

        run_search("busy_drop", 8'h77, 1, 0);

        // Reset lands at edge t+3, in the middle of a scan.
        @(negedge clk);
        srch_start = 1'b1;
        srch_key   = 8'hA5;
        @(negedge clk);
        srch_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_hit", hit, 0);
        check("midrst_hit_idx", hit_idx, 0);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
        pulses = 0;
        repeat (DEPTH + 4) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        run_search("post_rst_miss", 8'hA5, 0, 0);

        for (int it = 0; it < 30; it++) begin
            int n_wr, pick;
            logic [KEY_W-1:0] key;
            n_wr = int'($urandom_range(1, 3));
            for (int w = 0; w < n_wr; w++) begin
                write_entry(int'($urandom_range(0, DEPTH - 1)), KEY_W'($urandom),
                            KEY_W'($urandom & $urandom & $urandom),
                            ($urandom_range(0, 7) != 0));
            end
            pick = int'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 3) == 0) key = KEY_W'($urandom);
            else key = m_data[pick] ^ (m_mask[pick] & KEY_W'($urandom));
            if ($urandom_range(0, 7) == 0)
                run_search($sformatf("rnd%0d", it), key, 2, int'($urandom_range(0, DEPTH - 1)));
            else
                run_search($sformatf("rnd%0d", it), key, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
